// File: rtl/tl_ul_mem_slave.sv
// ============================================================================
// tl_ul_mem_slave : TileLink-UL single-outstanding memory slave
// Revision 1.0
// ============================================================================
`default_nettype none

module tl_ul_mem_slave #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    SRC_WIDTH    = 2,
    parameter int                    DEPTH        = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(32'h1000_0000),
    parameter int                    RESP_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [2:0]              a_opcode,
    input  logic [2:0]              a_param,
    input  logic [2:0]              a_size,
    input  logic [SRC_WIDTH-1:0]    a_source,
    input  logic [ADDR_WIDTH-1:0]   a_address,
    input  logic [DATA_WIDTH/8-1:0] a_mask,
    input  logic [DATA_WIDTH-1:0]   a_data,

    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [2:0]              d_opcode,
    output logic [2:0]              d_param,
    output logic [2:0]              d_size,
    output logic [SRC_WIDTH-1:0]    d_source,
    output logic                    d_sink,
    output logic [DATA_WIDTH-1:0]   d_data,
    output logic                    d_error
);

    localparam int                    c_MASK  = DATA_WIDTH / 8;
    localparam int                    c_IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_SPAN  = ADDR_WIDTH'(DEPTH * 4);
    localparam logic [3:0]            c_LAT   = 4'(RESP_LATENCY);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q,   cnt_d;
    logic [2:0]            d_opcode_q;
    logic [2:0]            d_size_q;
    logic [SRC_WIDTH-1:0]  d_source_q;
    logic [DATA_WIDTH-1:0] d_data_q;
    logic                  d_error_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] w_offset;
    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_in_range;
    logic                  w_is_get;
    logic                  w_is_put;
    logic                  w_error;
    logic                  w_accept;
    logic                  w_unused;

    assign w_offset   = a_address - BASE_ADDR;
    assign w_in_range = (a_address >= BASE_ADDR) && (w_offset < c_SPAN);
    assign w_idx      = w_offset[c_IDX_W+1:2];
    assign w_is_get   = (a_opcode == 3'd4);
    assign w_is_put   = (a_opcode == 3'd0) || (a_opcode == 3'd1);
    assign w_error    = !w_in_range || (a_address[1:0] != 2'b00) ||
                        (a_size > 3'd2) || !(w_is_get || w_is_put);
    assign w_accept   = a_valid && a_ready;
    assign w_unused   = ^{a_param, w_offset[ADDR_WIDTH-1:c_IDX_W+2], w_offset[1:0]};

    assign a_ready  = (state_q == S_IDLE);
    assign d_valid  = (state_q == S_RESP);
    assign d_opcode = d_opcode_q;
    assign d_param  = 3'd0;
    assign d_size   = d_size_q;
    assign d_source = d_source_q;
    assign d_sink   = 1'b0;
    assign d_data   = d_data_q;
    assign d_error  = d_error_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (c_LAT == 4'd0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = c_LAT;
                    end
                end
            end
            S_WAIT: begin
                // Counter is loaded with the latency, so a value of 1 marks the last wait cycle
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (d_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            d_opcode_q <= 3'd0;
            d_size_q   <= 3'd0;
            d_source_q <= '0;
            d_data_q   <= '0;
            d_error_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                d_opcode_q <= w_is_get ? 3'd1 : 3'd0;
                d_size_q   <= a_size;
                d_source_q <= a_source;
                d_error_q  <= w_error;
                d_data_q   <= (w_is_get && !w_error) ? mem_q[w_idx] : '0;
            end
        end
    end

    // Storage carries no reset; its contents are undefined until written
    always_ff @(posedge clk) begin
        if (w_accept && w_is_put && !w_error) begin
            for (int b = 0; b < c_MASK; b++) begin
                if (a_mask[b]) begin
                    mem_q[w_idx][b*8 +: 8] <= a_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/tl_ul_mem_slave.md
TL_UL_MEM_SLAVE -- requirements
Module: tl_ul_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, Channel A address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; MASK = DATA_WIDTH/8.
REQ-003 SHALL have parameter SRC_WIDTH, default 2, source ID width.
REQ-004 SHALL have parameter DEPTH, default 16, number of DATA_WIDTH words, power of two.
REQ-005 SHALL have parameter BASE_ADDR, default 32'h1000_0000, byte address of word 0.
REQ-006 SHALL have parameter RESP_LATENCY, default 1, extra wait cycles before d_valid, range 0..15.
REQ-007 SHALL have port clk  input  1  clock.
REQ-008 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have port a_valid  input  1  Channel A request valid.
REQ-010 SHALL have port a_ready  output  1  Channel A request accepted.
REQ-011 SHALL have port a_opcode  input  3  0=PutFullData, 1=PutPartialData, 4=Get.
REQ-012 SHALL have port a_param  input  3  ignored.
REQ-013 SHALL have port a_size  input  3  log2 bytes.
REQ-014 SHALL have port a_source  input  SRC_WIDTH  requester ID.
REQ-015 SHALL have port a_address  input  ADDR_WIDTH  byte address.
REQ-016 SHALL have port a_mask  input  MASK  byte-lane write enables.
REQ-017 SHALL have port a_data  input  DATA_WIDTH  write data.
REQ-018 SHALL have port d_valid  output  1  response valid.
REQ-019 SHALL have port d_ready  input  1  response accepted.
REQ-020 SHALL have port d_opcode  output  3  0=AccessAck, 1=AccessAckData.
REQ-021 SHALL have port d_param  output  3  always 0.
REQ-022 SHALL have port d_size  output  3  echo of captured a_size.
REQ-023 SHALL have port d_source  output  SRC_WIDTH  echo of captured a_source.
REQ-024 SHALL have port d_sink  output  1  always 0.
REQ-025 SHALL have port d_data  output  DATA_WIDTH  read data; 0 for AccessAck or error.
REQ-026 SHALL have port d_error  output  1  denied/corrupt response.

Function
REQ-027 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; a_ready = (state==IDLE), combinational from state only.
REQ-028 SHALL accept a request on a clk edge with a_valid && a_ready, capturing opcode, size, source, address, mask, data.
REQ-029 SHALL enter WAIT with counter = RESP_LATENCY on accept, or go directly to RESP if RESP_LATENCY==0.
REQ-030 SHALL decrement the counter each cycle in WAIT and enter RESP the cycle after it reaches 1.
REQ-031 SHALL hold d_valid=1 and all d_* fields stable in RESP until d_ready; on d_valid && d_ready, return to IDLE.
REQ-032 SHALL flag error if address is outside [BASE_ADDR, BASE_ADDR+DEPTH*4), address[1:0]!=0, a_size>2, or opcode not in {0,1,4}.
REQ-033 SHALL compute word index = (a_address-BASE_ADDR)>>2, truncated to log2(DEPTH) bits, only for in-range requests.
REQ-034 SHALL, for Put without error, write a_data byte lanes where a_mask=1 on the accept edge; other lanes unchanged.
REQ-035 SHALL, for Get without error, latch the word on the accept edge and return d_opcode=1; Puts return d_opcode=0.
REQ-036 SHALL, on error, perform no memory write, set d_error=1, d_data=0, and use d_opcode=1 for Get, 0 otherwise.
REQ-037 SHALL support one outstanding request; a_valid during WAIT/RESP is stalled, never dropped.
REQ-038 SHALL allow back-to-back transactions: a_ready rises the cycle after the D handshake.

Reset
REQ-039 SHALL, while reset=1, force state=IDLE, a_ready=1, d_valid=0, d_opcode/d_size/d_source/d_data/d_error=0, counter=0; memory contents undefined.
REQ-040 SHALL abort any in-flight transaction when reset asserts mid-WAIT or mid-RESP; no response is ever issued for it.

Verification
REQ-041 Put 0xDEADBEEF to 0x1000_0004, mask 0xF, source 2, latency 1 -> AccessAck, d_source=2, d_error=0, d_valid 2 cycles after accept.
REQ-042 Get 0x1000_0004 after REQ-041 -> AccessAckData, d_data=0xDEADBEEF, d_size=2.
REQ-043 PutPartialData 0x11223344 mask 0x5 to same word, then Get -> d_data=0xDE22BE44.
REQ-044 Get 0x1000_0040 (out of range) -> d_error=1, d_data=0, memory unchanged; Put to 0x1000_0002 -> d_error=1, no write.
REQ-045 Hold d_ready=0 for 5 cycles in RESP with a_valid=1 -> d_* stable, a_ready=0; raise d_ready -> next request accepted 1 cycle later.
REQ-046 Assert reset during WAIT -> d_valid stays 0, a_ready=1 after reset release, no stale response.
